// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data memory. Port 0 is the core
// load/store port and port 1 is the loader/debug port. One access is performed
// per grant cycle. A port is never granted on two consecutive cycles, so two
// ports that request continuously strictly alternate. A tie from IDLE goes to
// the port that was not granted most recently. After reset port 0 wins the
// first tie.
//
// Timing of an access to port x:
//   cycle N   : gntx high, memory bus driven from port x (addr/wdata/we)
//   edge N/N+1: memory written (write) or mem_rdata captured into rdatax (read)
//   cycle N+1 : rvalidx high for exactly one cycle (reads and writes alike)
//
// Parameters:
//   DATA_WIDTH - data word width
//   ADDR_WIDTH - byte address width
//   MEM_DEPTH  - number of words in the arbitrated memory
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req0/req1, we0/we1       - access request and write enable per port
//   addr0/addr1              - byte address per port
//   wdata0/wdata1            - write data per port
//   gnt0/gnt1                - high during the cycle the port is served
//   rvalid0/rvalid1          - one-cycle completion pulse after the grant
//   rdata0/rdata1            - last captured read data per port
//   err0/err1                - access error, coincident with rvalid
//   mem_w_en, mem_addr,
//   mem_wdata                - memory command bus (all zero while idle)
//   mem_rdata                - combinational read data from the memory
//
// Build option:
//   DMEM_ARB_RANGE_CHECK_EN - when defined, misaligned addresses or addresses
//   beyond MEM_DEPTH words are still granted, but the write strobe is
//   suppressed, rdata is cleared and err is raised with rvalid. When not
//   defined, err0/err1 are constant 0 and addresses pass through unchanged.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_grant;   // 0: port 0 served last, 1: port 1
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  r_err0;
    logic                  r_err1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  w_bad0;
    logic                  w_bad1;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(MEM_DEPTH);

    // An address is unusable if it is not word aligned or its word index
    // falls outside the memory.
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_WIDTH-1:2]} >= DEPTH_WORDS);
    endfunction

    assign w_bad0 = addr_bad(addr0);
    assign w_bad1 = addr_bad(addr1);
`else
    assign w_bad0 = 1'b0;
    assign w_bad1 = 1'b0;
`endif

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: leaving a grant always hands over or idles, which is
    // what keeps one port from being served twice in a row.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_next_state = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (req0) begin
                    w_next_state = ST_GRANT0;
                end else if (req1) begin
                    w_next_state = ST_GRANT1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                if (req1) begin
                    w_next_state = ST_GRANT1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (req0) begin
                    w_next_state = ST_GRANT0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: grant flags and memory bus straight from the state, so
    // an asynchronous reset drops mem_w_en at once.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_w_en  = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        case (r_state)
            ST_GRANT0: begin
                gnt0      = 1'b1;
                mem_w_en  = we0 & ~w_bad0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            ST_GRANT1: begin
                gnt1      = 1'b1;
                mem_w_en  = we1 & ~w_bad1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            default: begin
                gnt0      = 1'b0;
                gnt1      = 1'b0;
                mem_w_en  = 1'b0;
                mem_addr  = {ADDR_WIDTH{1'b0}};
                mem_wdata = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Remember which port was served last for tie breaking from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (r_state == ST_GRANT0) begin
            r_last_grant <= 1'b0;
        end else if (r_state == ST_GRANT1) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Port 0 completion: rvalid/err pulse, read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_err0    <= 1'b0;
            r_rdata0  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rvalid0 <= (r_state == ST_GRANT0);
            r_err0    <= (r_state == ST_GRANT0) && w_bad0;
            if (r_state == ST_GRANT0) begin
                if (w_bad0) begin
                    r_rdata0 <= {DATA_WIDTH{1'b0}};
                end else if (!we0) begin
                    r_rdata0 <= mem_rdata;
                end else begin
                    r_rdata0 <= r_rdata0;
                end
            end else begin
                r_rdata0 <= r_rdata0;
            end
        end
    end

    // Port 1 completion: rvalid/err pulse, read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid1 <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata1  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rvalid1 <= (r_state == ST_GRANT1);
            r_err1    <= (r_state == ST_GRANT1) && w_bad1;
            if (r_state == ST_GRANT1) begin
                if (w_bad1) begin
                    r_rdata1 <= {DATA_WIDTH{1'b0}};
                end else if (!we1) begin
                    r_rdata1 <= mem_rdata;
                end else begin
                    r_rdata1 <= r_rdata1;
                end
            end else begin
                r_rdata1 <= r_rdata1;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dmem_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level reference model (pending requests,
// least-recently-served tie break, no back-to-back service, word memory).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:DEPTH-1] = '{default: 32'h0};
    logic [DW-1:0] ref_mem [0:31]  = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-addressed memory behind the arbiter.
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Run one access on a port; returns what was seen during and after grant.
    task automatic do_access(input int port, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, output logic granted,
                             output logic mwe, output logic rv,
                             output logic [DW-1:0] rd, output logic er);
        granted = 1'b0;
        mwe     = 1'b0;
        if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
        else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
        for (int i = 0; i < 8 && !granted; i++) begin
            tick();
            granted = (port == 0) ? gnt0 : gnt1;
        end
        if (granted) mwe = mem_w_en;
        tick();
        rv = (port == 0) ? rvalid0 : rvalid1;
        rd = (port == 0) ? rdata0  : rdata1;
        er = (port == 0) ? err0    : err1;
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (gnt0 !== 1'b0)     begin n_fail++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
        n_checks++; if (gnt1 !== 1'b0)     begin n_fail++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
        n_checks++; if (rvalid0 !== 1'b0)  begin n_fail++; $display("FAIL reset_rvalid0: got %b want 0", rvalid0); end
        n_checks++; if (rvalid1 !== 1'b0)  begin n_fail++; $display("FAIL reset_rvalid1: got %b want 0", rvalid1); end
        n_checks++; if (err0 !== 1'b0)     begin n_fail++; $display("FAIL reset_err0: got %b want 0", err0); end
        n_checks++; if (err1 !== 1'b0)     begin n_fail++; $display("FAIL reset_err1: got %b want 0", err1); end
        n_checks++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_w_en: got %b want 0", mem_w_en); end
        n_checks++; if (rdata0 !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
        n_checks++; if (rdata1 !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL wr_no_early_gnt: got %b want 0", gnt0); end
        tick();
        n_checks++; if (gnt0 !== 1'b1)        begin n_fail++; $display("FAIL wr_gnt0: got %b want 1", gnt0); end
        n_checks++; if (mem_w_en !== 1'b1)    begin n_fail++; $display("FAIL wr_mem_w_en: got %b want 1", mem_w_en); end
        n_checks++; if (mem_addr !== 32'h10)  begin n_fail++; $display("FAIL wr_mem_addr: got %h want 10", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want deadbeef", mem_wdata); end
        tick();
        n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid0: got %b want 1", rvalid0); end
        n_checks++; if (gnt0 !== 1'b0)    begin n_fail++; $display("FAIL wr_no_b2b_gnt0: got %b want 0", gnt0); end
        n_checks++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL wr_rdata0_held: got %h want 0", rdata0); end
        n_checks++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_content: got %h want deadbeef", mem[4]); end
        we0 = 1'b0;
        tick();
        n_checks++; if (gnt0 !== 1'b1)     begin n_fail++; $display("FAIL rd_gnt0: got %b want 1", gnt0); end
        n_checks++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL rd_mem_w_en: got %b want 0", mem_w_en); end
        tick();
        req0 = 1'b0;
        n_checks++; if (rvalid0 !== 1'b1)        begin n_fail++; $display("FAIL rd_rvalid0: got %b want 1", rvalid0); end
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata0: got %h want deadbeef", rdata0); end
        tick();
        n_checks++; if (rvalid0 !== 1'b0)        begin n_fail++; $display("FAIL rd_rvalid0_pulse: got %b want 0", rvalid0); end
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata0_hold: got %h want deadbeef", rdata0); end
    endtask

    task automatic test_alternate;
        clear_inputs();
        rst = 1'b1;
        req0 = 1'b1; addr0 = 32'h10;
        req1 = 1'b1; addr1 = 32'h20;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (gnt0 !== ((k % 2) == 0)) begin n_fail++; $display("FAIL alt_gnt0[%0d]: got %b want %b", k, gnt0, (k % 2) == 0); end
            n_checks++; if (gnt1 !== ((k % 2) == 1)) begin n_fail++; $display("FAIL alt_gnt1[%0d]: got %b want %b", k, gnt1, (k % 2) == 1); end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_cross_port;
        logic g, mwe, rv, er;
        logic [DW-1:0] rd;
        do_access(0, 1'b0, 32'h10, 32'h0, g, mwe, rv, rd, er);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL xp_p0_read: got %h want deadbeef", rd); end
        do_access(0, 1'b1, 32'h20, 32'h5, g, mwe, rv, rd, er);
        n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL xp_p0_write_rvalid: got %b want 1", rv); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL xp_p0_write_keeps_rdata: got %h want deadbeef", rd); end
        do_access(1, 1'b0, 32'h20, 32'h0, g, mwe, rv, rd, er);
        n_checks++; if (g !== 1'b1)  begin n_fail++; $display("FAIL xp_p1_gnt: got %b want 1", g); end
        n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL xp_p1_rvalid: got %b want 1", rv); end
        n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL xp_p1_rdata: got %h want 5", rd); end
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL xp_rdata0_unchanged: got %h want deadbeef", rdata0); end
    endtask

    task automatic test_reset_abort;
        logic g, mwe, rv, er;
        logic [DW-1:0] rd;
        do_access(0, 1'b1, 32'h30, 32'h11112222, g, mwe, rv, rd, er);
        n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL ab_setup_gnt: got %b want 1", g); end
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'hBAD0BAD0;
        tick();
        n_checks++; if (gnt1 !== 1'b1)     begin n_fail++; $display("FAIL ab_gnt1: got %b want 1", gnt1); end
        n_checks++; if (mem_w_en !== 1'b1) begin n_fail++; $display("FAIL ab_mem_w_en_before: got %b want 1", mem_w_en); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL ab_mem_w_en_drop: got %b want 0", mem_w_en); end
        n_checks++; if (gnt1 !== 1'b0)     begin n_fail++; $display("FAIL ab_gnt1_drop: got %b want 0", gnt1); end
        clear_inputs();
        tick();
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL ab_rvalid1_in_reset: got %b want 0", rvalid1); end
        rst = 1'b0;
        tick();
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL ab_rvalid1_after: got %b want 0", rvalid1); end
        n_checks++; if (mem[12] !== 32'h11112222) begin n_fail++; $display("FAIL ab_mem_unchanged: got %h want 11112222", mem[12]); end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL ab_tie_gnt0: got %b want 1", gnt0); end
        n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL ab_tie_gnt1: got %b want 0", gnt1); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_range;
        logic g, mwe, rv, er;
        logic [DW-1:0] rd;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        logic [AW-1:0] bad_addr [2];
        bad_addr[0] = 32'h1000;
        bad_addr[1] = 32'h12;
        for (int i = 0; i < 2; i++) begin
            do_access(0, 1'b0, 32'h10, 32'h0, g, mwe, rv, rd, er);
            n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rng_pre_read[%0d]: got %h want deadbeef", i, rd); end
            do_access(0, 1'b1, bad_addr[i], 32'h55, g, mwe, rv, rd, er);
            n_checks++; if (g !== 1'b1)   begin n_fail++; $display("FAIL rng_gnt[%0d]: got %b want 1", i, g); end
            n_checks++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL rng_mem_w_en[%0d]: got %b want 0", i, mwe); end
            n_checks++; if (rv !== 1'b1)  begin n_fail++; $display("FAIL rng_rvalid[%0d]: got %b want 1", i, rv); end
            n_checks++; if (er !== 1'b1)  begin n_fail++; $display("FAIL rng_err[%0d]: got %b want 1", i, er); end
            n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rng_rdata[%0d]: got %h want 0", i, rd); end
        end
`else
        do_access(0, 1'b1, 32'h1000, 32'h55, g, mwe, rv, rd, er);
        n_checks++; if (g !== 1'b1)   begin n_fail++; $display("FAIL norng_gnt: got %b want 1", g); end
        n_checks++; if (mwe !== 1'b1) begin n_fail++; $display("FAIL norng_mem_w_en: got %b want 1", mwe); end
        n_checks++; if (rv !== 1'b1)  begin n_fail++; $display("FAIL norng_rvalid: got %b want 1", rv); end
        n_checks++; if (er !== 1'b0)  begin n_fail++; $display("FAIL norng_err: got %b want 0", er); end
`endif
    endtask

    // Random traffic against a transaction-level model.
    task automatic test_random(input int ncycles);
        bit            pend [2];
        logic          twe [2];
        logic [AW-1:0] tad [2];
        logic [DW-1:0] twd [2];
        logic [DW-1:0] exp_rd [2];
        logic [DW-1:0] cap_rd [2];
        bit            cap_is_rd [2];
        int            t_raise [2];
        int            cur, prev, nxt, last_served, p, idx, lat;
        bit            elig0, elig1;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; exp_rd[i] = '0; cap_is_rd[i] = 1'b0; t_raise[i] = 0;
            twe[i] = 1'b0; tad[i] = '0; twd[i] = '0; cap_rd[i] = '0;
        end
        prev = 0; nxt = 0; last_served = 1;
        for (int c = 0; c < ncycles; c++) begin
            tick();
            cur = nxt;
            if (prev != 0) begin
                p = prev - 1;
                pend[p] = 1'b0;
                if (cap_is_rd[p]) exp_rd[p] = cap_rd[p];
            end
            n_checks++; if (gnt0 !== (cur == 1))    begin n_fail++; $display("FAIL rnd_gnt0 c=%0d: got %b want %b", c, gnt0, cur == 1); end
            n_checks++; if (gnt1 !== (cur == 2))    begin n_fail++; $display("FAIL rnd_gnt1 c=%0d: got %b want %b", c, gnt1, cur == 2); end
            n_checks++; if (rvalid0 !== (prev == 1)) begin n_fail++; $display("FAIL rnd_rvalid0 c=%0d: got %b want %b", c, rvalid0, prev == 1); end
            n_checks++; if (rvalid1 !== (prev == 2)) begin n_fail++; $display("FAIL rnd_rvalid1 c=%0d: got %b want %b", c, rvalid1, prev == 2); end
            n_checks++; if (rdata0 !== exp_rd[0])   begin n_fail++; $display("FAIL rnd_rdata0 c=%0d: got %h want %h", c, rdata0, exp_rd[0]); end
            n_checks++; if (rdata1 !== exp_rd[1])   begin n_fail++; $display("FAIL rnd_rdata1 c=%0d: got %h want %h", c, rdata1, exp_rd[1]); end
            n_checks++; if ((err0 | err1) !== 1'b0) begin n_fail++; $display("FAIL rnd_err c=%0d: got %b%b want 00", c, err0, err1); end
            if (cur != 0) begin
                p = cur - 1;
                n_checks++; if (mem_w_en !== twe[p])  begin n_fail++; $display("FAIL rnd_mem_w_en c=%0d: got %b want %b", c, mem_w_en, twe[p]); end
                n_checks++; if (mem_addr !== tad[p])  begin n_fail++; $display("FAIL rnd_mem_addr c=%0d: got %h want %h", c, mem_addr, tad[p]); end
                n_checks++; if (mem_wdata !== twd[p]) begin n_fail++; $display("FAIL rnd_mem_wdata c=%0d: got %h want %h", c, mem_wdata, twd[p]); end
                lat = c - t_raise[p];
                n_checks++; if (lat < 1 || lat > 2)   begin n_fail++; $display("FAIL rnd_latency c=%0d: got %0d want 1..2", c, lat); end
                idx = int'((tad[p] - 32'h100) >> 2);
                if (twe[p]) begin
                    ref_mem[idx] = twd[p];
                    cap_is_rd[p] = 1'b0;
                end else begin
                    cap_rd[p]    = ref_mem[idx];
                    cap_is_rd[p] = 1'b1;
                end
                last_served = p;
            end else begin
                n_checks++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_w_en c=%0d: got %b want 0", c, mem_w_en); end
                n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rnd_idle_addr c=%0d: got %h want 0", c, mem_addr); end
                n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rnd_idle_wdata c=%0d: got %h want 0", c, mem_wdata); end
            end
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && ($urandom_range(0, 1) == 1)) begin
                    pend[q]    = 1'b1;
                    twe[q]     = 1'($urandom_range(0, 1));
                    tad[q]     = 32'h100 + 32'($urandom_range(0, 31)) * 32'd4;
                    twd[q]     = $urandom;
                    t_raise[q] = c;
                end
            end
            req0 = pend[0]; we0 = twe[0]; addr0 = tad[0]; wdata0 = twd[0];
            req1 = pend[1]; we1 = twe[1]; addr1 = tad[1]; wdata1 = twd[1];
            // A port being served now must sit out the next cycle; a tie
            // goes to whoever was served less recently.
            elig0 = pend[0] && (cur != 1);
            elig1 = pend[1] && (cur != 2);
            if (elig0 && elig1)  nxt = (last_served == 0) ? 2 : 1;
            else if (elig0)      nxt = 1;
            else if (elig1)      nxt = 2;
            else                 nxt = 0;
            prev = cur;
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_reset();
        test_alternate();
        test_cross_port();
        test_reset_abort();
        test_range();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
